// File: rtl/axis_egress_arb.sv
// axis_egress_arb: packet-atomic N:1 AXI-stream arbiter with a one-entry registered output stage.
// Ports:
//   clk, rst               clock and asynchronous active-high reset
//   s_tdata/s_tuser        packed per-port payload, port i at [i*W +: W]
//   s_tvalid/s_tlast       per-port valid and last
//   s_tready               per-port ready, only the granted port ever sees it
//   m_tdata/m_tuser/m_tlast/m_tvalid, m_tready   registered egress stream
//   grant_valid            high while a packet is granted
//   grant_idx              currently or most recently granted port
// Build option: define AXIS_EGRESS_ARB_PRIO_EN to give port 0 strict priority at each arbitration;
// otherwise all ports share a plain round-robin.
module axis_egress_arb #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int NUM_PORTS  = 4,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_tdata,
    input  logic [NUM_PORTS-1:0]             s_tvalid,
    output logic [NUM_PORTS-1:0]             s_tready,
    input  logic [NUM_PORTS-1:0]             s_tlast,
    input  logic [NUM_PORTS*USER_WIDTH-1:0]  s_tuser,
    output logic [DATA_WIDTH-1:0]            m_tdata,
    output logic                             m_tvalid,
    input  logic                             m_tready,
    output logic                             m_tlast,
    output logic [USER_WIDTH-1:0]            m_tuser,
    output logic                             grant_valid,
    output logic [IDX_W-1:0]                 grant_idx
);
    typedef enum logic {IDLE, PKT} state_t;
    state_t state, state_nxt;
    logic [IDX_W-1:0] last_grant, pick;
    logic out_ready, accept, sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [USER_WIDTH-1:0] sel_user;

    // First requester after `last` in circular order; descending scan so the nearest one wins.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] req, input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] r;
        r = last;
        for (int k = NUM_PORTS; k >= 1; k--)
            if (req[(int'(last) + k) % NUM_PORTS]) r = IDX_W'((int'(last) + k) % NUM_PORTS);
        return r;
    endfunction

`ifdef AXIS_EGRESS_ARB_PRIO_EN
    assign pick = s_tvalid[0] ? '0 : rr_pick(s_tvalid, last_grant);
`else
    assign pick = rr_pick(s_tvalid, last_grant);
`endif

    // The output slot can take a beat when empty or draining this cycle.
    assign out_ready = !m_tvalid || m_tready;
    assign sel_data  = s_tdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_user  = s_tuser[int'(grant_idx)*USER_WIDTH +: USER_WIDTH];
    assign sel_last  = s_tlast[grant_idx];
    assign accept    = state == PKT && s_tvalid[grant_idx] && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE && |s_tvalid) state_nxt = PKT;
        else if (accept && sel_last) state_nxt = IDLE;
    end

    always_comb begin
        s_tready    = (state == PKT && out_ready) ? NUM_PORTS'(1) << grant_idx : '0;
        grant_valid = state == PKT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_idx  <= '0;
            last_grant <= IDX_W'(NUM_PORTS - 1);
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            m_tlast    <= 1'b0;
            m_tuser    <= '0;
        end else begin
            if (state == IDLE && |s_tvalid) grant_idx <= pick;
            if (accept && sel_last) last_grant <= grant_idx;
            if (accept) begin
                m_tdata <= sel_data;
                m_tlast <= sel_last;
                m_tuser <= sel_user;
            end
            if (accept) m_tvalid <= 1'b1;
            else if (m_tready) m_tvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axis_egress_arb.sv
// tb_axis_egress_arb: directed and randomized checks of axis_egress_arb against a packet-level model.
module tb_axis_egress_arb;
    localparam int N = 4, DW = 16, UW = 1;
    logic clk = 1'b0, rst = 1'b0;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0] s_tvalid, s_tready, s_tlast;
    logic [N*UW-1:0] s_tuser;
    logic [DW-1:0] m_tdata;
    logic m_tvalid, m_tready, m_tlast;
    logic [UW-1:0] m_tuser;
    logic grant_valid;
    logic [1:0] grant_idx;
    int total = 0, bad = 0;
    int grants[$], firsts[$];

    always #5 clk = ~clk;

    axis_egress_arb #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .NUM_PORTS(N)) dut (
        .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tlast(s_tlast), .s_tuser(s_tuser), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .grant_valid(grant_valid), .grant_idx(grant_idx));

    // Arbitration rule: first requester after the last granted port, port 0 first when prioritised.
    function automatic int ref_pick(input logic [N-1:0] req, input int last);
`ifdef AXIS_EGRESS_ARB_PRIO_EN
        if (req[0]) return 0;
`endif
        for (int k = 1; k <= N; k++) if (req[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic logic [DW-1:0] beat(input int p, input int n, input int b);
        return DW'((p << 12) | ((n & 255) << 4) | (b & 15));
    endfunction

    task automatic set_port(input int p, input logic v, input logic [DW-1:0] d, input logic l);
        s_tvalid[p] = v;
        s_tdata[p*DW +: DW] = d;
        s_tlast[p] = l;
        s_tuser[p] = ^d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tuser = '0; m_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset m_tvalid got=%0b want=0", m_tvalid); end
        total++; if (m_tdata !== '0) begin bad++; $display("FAIL reset m_tdata got=%h want=0", m_tdata); end
        total++; if (m_tlast !== 1'b0 || m_tuser !== '0) begin bad++; $display("FAIL reset m_tlast/m_tuser got=%0b/%0b want=0/0", m_tlast, m_tuser); end
        total++; if (s_tready !== '0) begin bad++; $display("FAIL reset s_tready got=%b want=0000", s_tready); end
        total++; if (grant_valid !== 1'b0 || grant_idx !== 2'd0) begin bad++; $display("FAIL reset grant got=%0b/%0d want=0/0", grant_valid, grant_idx); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_packet();
        do_reset();
        m_tready = 1'b1;
        set_port(2, 1'b1, 16'hA0, 1'b0);
        @(negedge clk);
        total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL single arb_cycle grant_valid got=%0b want=0", grant_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (grant_valid !== 1'b1 || grant_idx !== 2'd2 || s_tready !== 4'b0100)
            begin bad++; $display("FAIL single grant got=%0b/%0d/%b want=1/2/0100", grant_valid, grant_idx, s_tready); end
        for (int b = 0; b < 3; b++) begin
            @(posedge clk); #1;
            if (b < 2) set_port(2, 1'b1, DW'(16'hA1 + b), b == 1);
            else set_port(2, 1'b0, '0, 1'b0);
            @(negedge clk);
            total++; if (m_tvalid !== 1'b1 || m_tdata !== DW'(16'hA0 + b) || m_tlast !== (b == 2))
                begin bad++; $display("FAIL single beat%0d got=%0b/%h/%0b want=1/%h/%0b", b, m_tvalid, m_tdata, m_tlast, 16'hA0 + b, b == 2); end
        end
        total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL single back_to_idle grant_valid got=%0b want=0", grant_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL single drained m_tvalid got=%0b want=0", m_tvalid); end
        @(posedge clk); #1;
    endtask

    task automatic test_valid_stall();
        do_reset();
        m_tready = 1'b1;
        set_port(1, 1'b1, 16'h10, 1'b0);
        set_port(3, 1'b1, 16'h30, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (grant_idx !== 2'd1 || s_tready !== 4'b0010) begin bad++; $display("FAIL stall grant got=%0d/%b want=1/0010", grant_idx, s_tready); end
        @(posedge clk); #1;
        set_port(1, 1'b0, 16'h11, 1'b1);
        repeat (3) begin
            @(negedge clk);
            total++; if (grant_valid !== 1'b1 || grant_idx !== 2'd1 || s_tready[3] !== 1'b0)
                begin bad++; $display("FAIL stall hold got=%0b/%0d/%b want=1/1/0xxx", grant_valid, grant_idx, s_tready); end
            @(posedge clk); #1;
        end
        set_port(1, 1'b1, 16'h11, 1'b1);
        @(negedge clk);
        total++; if (s_tready !== 4'b0010) begin bad++; $display("FAIL stall resume s_tready got=%b want=0010", s_tready); end
        @(posedge clk); #1;
        set_port(1, 1'b0, '0, 1'b0);
        @(negedge clk);
        total++; if (grant_valid !== 1'b0 || s_tready !== '0) begin bad++; $display("FAIL stall idle got=%0b/%b want=0/0000", grant_valid, s_tready); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (grant_idx !== 2'd3 || s_tready !== 4'b1000) begin bad++; $display("FAIL stall next_grant got=%0d/%b want=3/1000", grant_idx, s_tready); end
        @(posedge clk); #1;
        set_port(3, 1'b0, '0, 1'b0);
        @(negedge clk);
        total++; if (m_tdata !== 16'h30 || m_tlast !== 1'b1) begin bad++; $display("FAIL stall port3_beat got=%h/%0b want=0030/1", m_tdata, m_tlast); end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        do_reset();
        m_tready = 1'b1;
        set_port(2, 1'b1, 16'hB0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        set_port(2, 1'b1, 16'hB1, 1'b0);
        total++; if (m_tvalid !== 1'b1 || m_tdata !== 16'hB0) begin bad++; $display("FAIL midrst first_beat got=%0b/%h want=1/00b0", m_tvalid, m_tdata); end
        #1 rst = 1'b1;
        #1;
        total++; if (m_tvalid !== 1'b0 || grant_valid !== 1'b0 || s_tready !== '0)
            begin bad++; $display("FAIL midrst async got=%0b/%0b/%b want=0/0/0000", m_tvalid, grant_valid, s_tready); end
        set_port(2, 1'b0, '0, 1'b0);
        set_port(0, 1'b1, 16'hC0, 1'b1);
        set_port(1, 1'b1, 16'hD0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (grant_valid !== 1'b1 || grant_idx !== 2'd0) begin bad++; $display("FAIL midrst rearb got=%0b/%0d want=1/0", grant_valid, grant_idx); end
        @(posedge clk); #1;
        s_tvalid = '0;
    endtask

    // Packet sources plus scoreboard: accepted beats queue up in order and must leave unchanged.
    task automatic run_traffic(input logic [N-1:0] mask, input int npk, input int plen, input int vprob, input int rprob, input string tag);
        int left[N], pn[N], bi[N], len[N];
        logic [DW+1:0] q[$];
        logic [N-1:0] exp_rdy;
        logic st, ordy, fire_last, newg;
        int m_last, cur, g_hold, busy, cyc;
        do_reset();
        grants.delete(); firsts.delete();
        m_last = N - 1; cur = 0; g_hold = 0; st = 1'b0; newg = 1'b0; busy = 0;
        for (int p = 0; p < N; p++) begin
            left[p] = mask[p] ? npk : 0; pn[p] = 0; bi[p] = 0;
            len[p] = plen > 0 ? plen : int'($urandom_range(1, 4));
        end
        for (cyc = 0; cyc < 4000; cyc++) begin
            busy = 0;
            for (int p = 0; p < N; p++) busy += left[p];
            if (busy == 0 && q.size() == 0 && !st) break;
            for (int p = 0; p < N; p++)
                set_port(p, left[p] > 0 && $urandom_range(99) < vprob, beat(p, pn[p], bi[p]), bi[p] == len[p] - 1);
            m_tready = $urandom_range(99) < rprob;
            @(negedge clk);
            total++;
            if (grant_valid !== st || grant_idx !== g_hold)
                begin bad++; $display("FAIL %s grant cyc=%0d got=%0b/%0d want=%0b/%0d", tag, cyc, grant_valid, grant_idx, st, g_hold); end
            if (newg) grants.push_back(int'(grant_idx));
            ordy = q.size() == 0 || m_tready;
            exp_rdy = '0;
            if (st && ordy) exp_rdy[cur] = 1'b1;
            total++;
            if (s_tready !== exp_rdy) begin bad++; $display("FAIL %s ready cyc=%0d got=%b want=%b", tag, cyc, s_tready, exp_rdy); end
            total++;
            if (m_tvalid !== (q.size() != 0) || (q.size() != 0 && {m_tuser, m_tlast, m_tdata} !== q[0]))
                begin bad++; $display("FAIL %s out cyc=%0d got=%0b/%h want=%0b/%h", tag, cyc, m_tvalid, {m_tuser, m_tlast, m_tdata}, q.size() != 0, q.size() != 0 ? q[0] : '0); end
            if (q.size() != 0 && m_tready) void'(q.pop_front());
            fire_last = 1'b0;
            newg = 1'b0;
            if (st && ordy && s_tvalid[cur]) begin
                if (bi[cur] == 0) firsts.push_back(cyc);
                q.push_back({s_tuser[cur], s_tlast[cur], s_tdata[cur*DW +: DW]});
                if (bi[cur] == len[cur] - 1) begin
                    fire_last = 1'b1; m_last = cur; left[cur]--; pn[cur]++; bi[cur] = 0;
                    len[cur] = plen > 0 ? plen : int'($urandom_range(1, 4));
                end else bi[cur]++;
            end
            if (!st && s_tvalid != '0) begin
                cur = ref_pick(s_tvalid, m_last); g_hold = cur; st = 1'b1; newg = 1'b1;
            end else if (fire_last) st = 1'b0;
            @(posedge clk); #1;
        end
        total++;
        if (busy != 0 || q.size() != 0) begin bad++; $display("FAIL %s budget packets_left=%0d queued=%0d want=0/0", tag, busy, q.size()); end
        s_tvalid = '0;
    endtask

    task automatic test_round_robin();
        int exp_g[5] = '{0, 1, 2, 3, 0};
        run_traffic(4'hF, 2, 2, 100, 100, "rr");
        for (int i = 0; i < 5; i++) begin
            total++;
            if (grants.size() <= i || grants[i] != exp_g[i]) begin bad++; $display("FAIL rr order[%0d] got=%0d want=%0d", i, grants.size() > i ? grants[i] : -1, exp_g[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (firsts.size() <= i + 1 || firsts[i+1] - firsts[i] != 3) begin bad++; $display("FAIL rr bubble[%0d] got=%0d want=3", i, firsts.size() > i + 1 ? firsts[i+1] - firsts[i] : -1); end
        end
    endtask

    task automatic test_priority();
`ifdef AXIS_EGRESS_ARB_PRIO_EN
        int exp_g[4] = '{0, 0, 0, 0};
`else
        int exp_g[4] = '{0, 2, 0, 2};
`endif
        run_traffic(4'b0101, 4, 1, 100, 100, "prio");
        for (int i = 0; i < 4; i++) begin
            total++;
            if (grants.size() <= i || grants[i] != exp_g[i]) begin bad++; $display("FAIL prio order[%0d] got=%0d want=%0d", i, grants.size() > i ? grants[i] : -1, exp_g[i]); end
        end
    endtask

    task automatic test_random();
        run_traffic(4'hF, 6, 0, 60, 60, "rand_a");
        run_traffic(4'hF, 6, 0, 90, 35, "rand_b");
        run_traffic(4'b1010, 5, 0, 75, 50, "rand_c");
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_valid_stall();
        test_mid_reset();
        test_round_robin();
        test_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
